// File: rtl/peripheral_uart_tx_serializer_pkg.sv
// rtl/peripheral_uart_tx_serializer_pkg.sv - shared UART types, length codes and helpers
// Contents:
//   uart_tx_state_t   transmitter state encoding
//   UART_LEN_5..8     cfg_len encodings
//   uart_data_bits()  data-bit count (5..8) for a cfg_len code
//   uart_parity()     parity bit over the used data bits
package peripheral_uart_pkg;

    typedef enum logic [2:0] {
        UART_TX_IDLE   = 3'd0,
        UART_TX_START  = 3'd1,
        UART_TX_DATA   = 3'd2,
        UART_TX_PARITY = 3'd3,
        UART_TX_STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic [1:0] UART_LEN_5 = 2'b00;
    localparam logic [1:0] UART_LEN_6 = 2'b01;
    localparam logic [1:0] UART_LEN_7 = 2'b10;
    localparam logic [1:0] UART_LEN_8 = 2'b11;

    function automatic logic [3:0] uart_data_bits(input logic [1:0] len);
        return 4'd5 + {2'b00, len};
    endfunction

    // Only the low 5..8 bits take part; the upper character bits are masked.
    // Odd parity is the inverse of the plain XOR.
    function automatic logic uart_parity(input logic [7:0] data,
                                         input logic [1:0] len,
                                         input logic       even);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - len);
        return (^(data & mask)) ^ ~even;
    endfunction

endpackage

// File: rtl/peripheral_uart_tx_serializer_if.sv
// rtl/peripheral_uart_tx_serializer_if.sv - FIFO read-side handshake bundle
// Signals:
//   data   character from the FIFO
//   valid  FIFO has a character
//   ready  consumer pops the character when high together with valid
// Modports: master = FIFO side, slave = serializer side.
interface peripheral_uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/peripheral_uart_tx_serializer_baud_tick.sv
// rtl/peripheral_uart_tx_serializer_baud_tick.sv - loadable bit-period down-counter
// Ports:
//   clk_i, rstn_i  clock, async active-low reset
//   clr_i          synchronous clear of the counter
//   restart_i      load div_i, starting a fresh period
//   en_i           count while high
//   div_i          period length minus one
//   tick_o         one-cycle pulse on the last clock of each period
module peripheral_uart_baud_tick #(
    parameter int DIVISOR_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     clr_i,
    input  logic                     restart_i,
    input  logic                     en_i,
    input  logic [DIVISOR_WIDTH-1:0] div_i,
    output logic                     tick_o
);

    logic [DIVISOR_WIDTH-1:0] cnt_q;

    // The period ends on the clock the counter sits at zero; the reload
    // happens on that same edge so consecutive periods are seamless.
    assign tick_o = en_i && (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (restart_i) begin
            cnt_q <= div_i;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                cnt_q <= div_i;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/peripheral_uart_tx_serializer.sv
// rtl/peripheral_uart_tx_serializer.sv - UART transmit serializer fed from the TX FIFO
// Ports:
//   clk_i, rstn_i     clock, async active-low reset
//   clr_i             synchronous abort of the current frame
//   cfg_div_i         bit period = cfg_div_i+1 clocks
//   cfg_len_i         data bits 5..8
//   cfg_par_en_i      parity enable
//   cfg_par_even_i    1 = even, 0 = odd parity
//   cfg_stop2_i       two stop bits when high
//   fifo_if           FIFO read handshake (data/valid in, ready out)
//   tx_o              registered serial line, idle high
//   busy_o            frame in progress
//   done_o            pulse on the final clock of a frame
module peripheral_uart_tx_serializer
    import peripheral_uart_pkg::*;
#(
    parameter int DIVISOR_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       clr_i,
    input  logic [DIVISOR_WIDTH-1:0]   cfg_div_i,
    input  logic [1:0]                 cfg_len_i,
    input  logic                       cfg_par_en_i,
    input  logic                       cfg_par_even_i,
    input  logic                       cfg_stop2_i,
    peripheral_uart_tx_serializer_if.slave fifo_if,
    output logic                       tx_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam logic [2:0] S_IDLE   = 3'(UART_TX_IDLE);
    localparam logic [2:0] S_START  = 3'(UART_TX_START);
    localparam logic [2:0] S_DATA   = 3'(UART_TX_DATA);
    localparam logic [2:0] S_PARITY = 3'(UART_TX_PARITY);
    localparam logic [2:0] S_STOP   = 3'(UART_TX_STOP);

    logic [2:0]               state_q;
    logic [2:0]               bit_idx_q;
    logic [7:0]               shift_q;
    logic [1:0]               len_q;
    logic                     par_en_q;
    logic                     par_q;
    logic                     stop2_q;
    logic [DIVISOR_WIDTH-1:0] div_q;
    logic                     tx_q;
    logic                     busy_q;

    logic                     tick;
    logic                     terminal;
    logic                     accept;
    logic                     ready;
    logic [2:0]               last_idx;
    logic [DIVISOR_WIDTH-1:0] timer_div;

    assign last_idx = 3'(uart_data_bits(len_q) - 4'd1);

    // In STOP, bit_idx counts stop bits: the frame ends on the tick of
    // stop bit 0 (one stop) or stop bit 1 (two stops).
    assign terminal = (state_q == S_STOP) && tick && (bit_idx_q == {2'b00, stop2_q});

    // Derived from state and counters only so the FIFO never sees a
    // combinational path from its own valid back into ready.
    assign ready  = !clr_i && ((state_q == S_IDLE) || terminal);
    assign accept = ready && fifo_if.valid;

    assign fifo_if.ready = ready;
    assign tx_o          = tx_q;
    assign busy_o        = busy_q;
    assign done_o        = terminal && !clr_i;

    // The accepting edge restarts the period from the live divisor because
    // the shadow copy is only written on that same edge.
    assign timer_div = accept ? cfg_div_i : div_q;

    peripheral_uart_baud_tick #(
        .DIVISOR_WIDTH (DIVISOR_WIDTH)
    ) u_baud_tick (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .clr_i     (clr_i),
        .restart_i (accept),
        .en_i      (state_q != S_IDLE),
        .div_i     (timer_div),
        .tick_o    (tick)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            len_q     <= '0;
            par_en_q  <= 1'b0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            div_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else if (clr_i) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else if (accept) begin
            shift_q   <= fifo_if.data[7:0];
            len_q     <= cfg_len_i;
            par_en_q  <= cfg_par_en_i;
            par_q     <= uart_parity(fifo_if.data[7:0], cfg_len_i, cfg_par_even_i);
            stop2_q   <= cfg_stop2_i;
            div_q     <= cfg_div_i;
            state_q   <= S_START;
            bit_idx_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
        end else if (tick) begin
            case (state_q)
                S_START: begin
                    state_q   <= S_DATA;
                    bit_idx_q <= '0;
                    tx_q      <= shift_q[0];
                    shift_q   <= shift_q >> 1;
                end
                S_DATA: begin
                    if (bit_idx_q == last_idx) begin
                        bit_idx_q <= '0;
                        if (par_en_q) begin
                            state_q <= S_PARITY;
                            tx_q    <= par_q;
                        end else begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                    end
                end
                S_PARITY: begin
                    state_q   <= S_STOP;
                    bit_idx_q <= '0;
                    tx_q      <= 1'b1;
                end
                S_STOP: begin
                    if (terminal) begin
                        state_q   <= S_IDLE;
                        bit_idx_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end
                    tx_q <= 1'b1;
                end
                default: begin
                    state_q   <= S_IDLE;
                    bit_idx_q <= '0;
                    tx_q      <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_uart_tx_serializer.sv
// tb/tb_peripheral_uart_tx_serializer.sv - scoreboard bench for the UART TX serializer
module tb_peripheral_uart_tx_serializer;

    typedef struct packed {
        logic tx;
        logic busy;
        logic ready;
        logic done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] cfg_div = '0;
    logic [1:0]  cfg_len = 2'b11;
    logic        cfg_par_en = 1'b0;
    logic        cfg_par_even = 1'b0;
    logic        cfg_stop2 = 1'b0;
    logic        tx, busy, done;

    peripheral_uart_tx_serializer_if #(.DATA_WIDTH(8)) fifo_if ();

    peripheral_uart_tx_serializer #(
        .DIVISOR_WIDTH (16),
        .DATA_WIDTH    (8)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .clr_i          (clr),
        .cfg_div_i      (cfg_div),
        .cfg_len_i      (cfg_len),
        .cfg_par_en_i   (cfg_par_en),
        .cfg_par_even_i (cfg_par_even),
        .cfg_stop2_i    (cfg_stop2),
        .fifo_if        (fifo_if),
        .tx_o           (tx),
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   cur_test = 0;
    int   pops = 0;
    int   mon_idx = 0;
    bit   armed = 1'b0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL test%0d %s: got %0h expected %0h", cur_test, name, act, exp);
        end
    endtask

    // Monitor: once a pop has been seen, every following clock is compared
    // against the next expected entry until the queue drains.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    mon_idx++;
                    chk($sformatf("tx clk%0d", mon_idx), tx, e.tx);
                    chk($sformatf("busy clk%0d", mon_idx), busy, e.busy);
                    chk($sformatf("ready clk%0d", mon_idx), fifo_if.ready, e.ready);
                    chk($sformatf("done clk%0d", mon_idx), done, e.done);
                end
                if (exp_q.size() == 0) armed = 1'b0;
            end
            if (fifo_if.valid && fifo_if.ready) begin
                pops++;
                if (!armed) mon_idx = 0;
                armed = 1'b1;
            end
        end
    end

    task automatic push_entry(input logic t, input logic b, input logic r, input logic d);
        exp_t e;
        e.tx = t; e.busy = b; e.ready = r; e.done = d;
        exp_q.push_back(e);
    endtask

    // bits: leftmost (bit nbits-1) is the first level on the line.
    task automatic push_frame(input logic [15:0] bits, input int nbits, input int div, input bit chained);
        logic last;
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c <= div; c++) begin
                last = (i == nbits - 1) && (c == div);
                push_entry(bits[nbits-1-i], 1'b1, last, last);
            end
        end
        if (!chained) push_entry(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic wait_pop(output int c);
        logic hs;
        c = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            hs = fifo_if.valid && fifo_if.ready;
            @(posedge clk);
            #1;
            if (hs) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("pop timeout", 32'd1, 32'd0);
    endtask

    task automatic start_frame(input logic [7:0] d);
        int c;
        fifo_if.data  = d;
        fifo_if.valid = 1'b1;
        wait_pop(c);
        fifo_if.valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || armed) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) begin
            chk("drain timeout", 32'd1, 32'd0);
            exp_q.delete();
            armed = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int div, input logic [1:0] len, input logic pe,
                           input logic even, input logic s2);
        cfg_div = 16'(div); cfg_len = len; cfg_par_en = pe;
        cfg_par_even = even; cfg_stop2 = s2;
    endtask

    initial begin
        int p1, p2;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p1, p2;
        fifo_if.data  = 8'h00;
        fifo_if.valid = 1'b0;

        // Test 1: reset values, then 100 idle clocks with no change
        cur_test = 1;
        repeat (3) @(negedge clk);
        chk("rst tx", tx, 1'b1);
        chk("rst ready", fifo_if.ready, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) push_entry(1'b1, 1'b0, 1'b1, 1'b0);
        armed = 1'b1;
        mon_idx = 0;
        wait_drain();

        // Test 2: div=3, 8N1, 0x55
        cur_test = 2;
        set_cfg(3, 2'b11, 1'b0, 1'b0, 1'b0);
        push_frame(16'b0101010101, 10, 3, 1'b0);
        start_frame(8'h55);
        wait_drain();

        // Test 3: div=0, 7E2, 0x41
        cur_test = 3;
        set_cfg(0, 2'b10, 1'b1, 1'b1, 1'b1);
        push_frame(16'b01000001011, 11, 0, 1'b0);
        start_frame(8'h41);
        wait_drain();

        // Test 4: div=0, 5O1, 0xFF
        cur_test = 4;
        set_cfg(0, 2'b00, 1'b1, 1'b0, 1'b0);
        push_frame(16'b01111101, 8, 0, 1'b0);
        start_frame(8'hFF);
        wait_drain();

        // Test 5: back-to-back 0xA5, 0x3C at div=1, 8N1
        cur_test = 5;
        set_cfg(1, 2'b11, 1'b0, 1'b0, 1'b0);
        push_frame(16'b0101001011, 10, 1, 1'b1);
        push_frame(16'b0001111001, 10, 1, 1'b0);
        fifo_if.data  = 8'hA5;
        fifo_if.valid = 1'b1;
        wait_pop(p1);
        fifo_if.data  = 8'h3C;
        wait_pop(p2);
        fifo_if.valid = 1'b0;
        chk("pop spacing", 32'(p2 - p1), 32'd20);
        wait_drain();

        // Test 6a: clr during data bit 3 (div=1, 8N1, 0x07)
        cur_test = 6;
        set_cfg(1, 2'b11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) push_entry(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) push_entry(1'b1, 1'b1, 1'b0, 1'b0);
        push_entry(1'b0, 1'b1, 1'b0, 1'b0);
        push_entry(1'b1, 1'b0, 1'b0, 1'b0);
        push_entry(1'b1, 1'b0, 1'b1, 1'b0);
        start_frame(8'h07);
        repeat (8) @(posedge clk);
        #1;
        clr = 1'b1;
        fifo_if.data  = 8'h00;
        fifo_if.valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        fifo_if.valid = 1'b0;
        wait_drain();

        // Test 6b: config changed mid-frame keeps the latched settings
        cur_test = 7;
        set_cfg(2, 2'b11, 1'b0, 1'b0, 1'b0);
        push_frame(16'b0010110101, 10, 2, 1'b0);
        start_frame(8'h5A);
        set_cfg(0, 2'b00, 1'b1, 1'b1, 1'b1);
        wait_drain();

        // Test 7: async reset mid-frame forces the line high at once
        cur_test = 8;
        set_cfg(3, 2'b11, 1'b0, 1'b0, 1'b0);
        start_frame(8'h00);
        repeat (10) @(posedge clk);
        #3;
        chk("pre-reset tx low", tx, 1'b0);
        rstn = 1'b0;
        #1;
        chk("async rst tx", tx, 1'b1);
        chk("async rst busy", busy, 1'b0);
        chk("async rst done", done, 1'b0);
        chk("async rst ready", fifo_if.ready, 1'b1);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        chk("total pops", 32'(pops), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
